// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative data cache.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;
  typedef enum logic [1:0] {OP_LD, OP_ST, OP_INV} op_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // index width that stays legal when the count is 1
  function automatic int sel_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int idx_w(input int sets);
    return clog2(sets);
  endfunction

  function automatic int off_w(input int data_w);
    return clog2(data_w / 8);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w, input int sets, input int words);
    return addr_w - clog2(sets) - clog2(words) - off_w(data_w);
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set age-based LRU: MRU update port and invalid-first / oldest victim pick.
module cache_lru
  import cache_pkg::*;
#(
  parameter int SETS = 64,
  parameter int WAYS = 2,
  localparam int IDX_W = idx_w(SETS),
  localparam int WAY_W = sel_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] idx,
  input  logic [WAYS-1:0]  valid,
  input  logic             upd,
  input  logic [WAY_W-1:0] upd_way,
  output logic [WAY_W-1:0] victim
);

  logic [WAY_W-1:0] age [SETS][WAYS];
  logic [WAY_W-1:0] cur;
  logic             found;

  assign cur = age[idx][upd_way];

  // ages remain a permutation: only ways younger than the touched one shift
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= WAY_W'(w);
    end else if (upd) begin
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == upd_way) age[idx][w] <= '0;
        else if (age[idx][w] < cur) age[idx][w] <= age[idx][w] + 1'b1;
      end
    end
  end

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++)
        if (age[idx][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/param_cache_ctrl.sv
// N-way write-back / write-allocate data cache with miss refill, dirty
// write-back and line invalidate between a CPU word port and a line-wide memory port.
module param_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 64,
  parameter int WAYS   = 2,
  parameter int WORDS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic                    cpu_inv,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W-1:0]       cpu_din,
  output logic                    cpu_ready,
  output logic [DATA_W-1:0]       cpu_dout,
  output logic                    cpu_hit,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [WORDS*DATA_W-1:0] mem_dout,
  input  logic [WORDS*DATA_W-1:0] mem_din,
  input  logic                    mem_ack
);

  localparam int OFF_W  = off_w(DATA_W);
  localparam int IDX_W  = idx_w(SETS);
  localparam int WSEL_W = sel_w(WORDS);
  localparam int TAG_W  = tag_w(ADDR_W, DATA_W, SETS, WORDS);
  localparam int LOW_W  = ADDR_W - TAG_W - IDX_W;
  localparam int WAY_W  = sel_w(WAYS);

  typedef struct packed {
    op_t               op;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] wsel;
    logic [DATA_W-1:0] din;
  } req_t;

  logic [TAG_W-1:0]             tag_mem  [WAYS][SETS];
  logic [WORDS-1:0][DATA_W-1:0] data_mem [WAYS][SETS];
  logic [WAYS-1:0]              valid [SETS];
  logic [WAYS-1:0]              dirty [SETS];

  state_t           state, nxt;
  req_t             req;
  logic             first;
  logic [WAY_W-1:0] vic, lru_vic, hit_way, clr_way;
  logic [WAYS-1:0]  hit_vec;
  logic             hit_any, accept;
  logic             done, acc_upd, inv_clr, fill;
  logic             unused_addr;

  assign accept      = (state == IDLE) && cpu_req;
  assign unused_addr = ^(cpu_addr & ADDR_W'((1 << OFF_W) - 1));

  for (genvar w = 0; w < WAYS; w++) begin : g_cmp
    assign hit_vec[w] = valid[req.idx][w] && (tag_mem[w][req.idx] == req.tag);
  end

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = WAY_W'(w);
  end
  assign hit_any = |hit_vec;

  cache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
    .clk     (clk),
    .rst     (rst),
    .idx     (req.idx),
    .valid   (valid[req.idx]),
    .upd     (acc_upd),
    .upd_way (hit_way),
    .victim  (lru_vic)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (cpu_req) nxt = COMPARE;
      COMPARE: begin
        if (hit_any)
          nxt = (req.op == OP_INV && dirty[req.idx][hit_way]) ? WRITE_BACK : IDLE;
        else if (req.op == OP_INV)
          nxt = IDLE;
        else if (valid[req.idx][lru_vic] && dirty[req.idx][lru_vic])
          nxt = WRITE_BACK;
        else
          nxt = ALLOCATE;
      end
      WRITE_BACK: if (mem_ack) nxt = (req.op == OP_INV) ? IDLE : ALLOCATE;
      ALLOCATE:   if (mem_ack) nxt = COMPARE;
      default:    nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_dout = '0;
    done     = 1'b0;
    acc_upd  = 1'b0;
    inv_clr  = 1'b0;
    clr_way  = hit_way;
    fill     = 1'b0;
    case (state)
      COMPARE: begin
        if (req.op == OP_INV) begin
          if (!hit_any) done = 1'b1;
          else if (!dirty[req.idx][hit_way]) begin
            done    = 1'b1;
            inv_clr = 1'b1;
          end
        end else if (hit_any) begin
          done    = 1'b1;
          acc_upd = 1'b1;
        end
      end
      WRITE_BACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {tag_mem[vic][req.idx], req.idx, {LOW_W{1'b0}}};
        mem_dout = data_mem[vic][req.idx];
        clr_way  = vic;
        if (mem_ack && req.op == OP_INV) begin
          done    = 1'b1;
          inv_clr = 1'b1;
        end
      end
      ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {req.tag, req.idx, {LOW_W{1'b0}}};
        fill     = mem_ack;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept)
      req <= '{op:   cpu_inv ? OP_INV : (cpu_we ? OP_ST : OP_LD),
               tag:  cpu_addr[ADDR_W-1 -: TAG_W],
               idx:  cpu_addr[LOW_W +: IDX_W],
               wsel: cpu_addr[OFF_W +: WSEL_W] & WSEL_W'(WORDS - 1),
               din:  cpu_din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first     <= 1'b0;
      vic       <= '0;
      cpu_ready <= 1'b0;
      cpu_dout  <= '0;
      cpu_hit   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
      end
    end else begin
      cpu_ready <= done;
      // a request that ever misses never reports a hit, even after refill
      if (accept) first <= 1'b1;
      else if (state == COMPARE && !hit_any) first <= 1'b0;
      if (state == COMPARE) vic <= hit_any ? hit_way : lru_vic;
      if (done) cpu_hit <= first && (state == WRITE_BACK || hit_any);
      if (done && state == COMPARE && req.op == OP_LD)
        cpu_dout <= data_mem[hit_way][req.idx][req.wsel];
      if (acc_upd && req.op == OP_ST) dirty[req.idx][hit_way] <= 1'b1;
      if (inv_clr) begin
        valid[req.idx][clr_way] <= 1'b0;
        dirty[req.idx][clr_way] <= 1'b0;
      end
      if (fill) begin
        valid[req.idx][vic] <= 1'b1;
        dirty[req.idx][vic] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      data_mem[vic][req.idx] <= mem_din;
      tag_mem[vic][req.idx]  <= req.tag;
    end
    if (acc_upd && req.op == OP_ST)
      data_mem[hit_way][req.idx][req.wsel] <= req.din;
  end

endmodule

// File: tb/tb_param_cache_ctrl.sv
// Directed bench for param_cache_ctrl: expected responses queued at issue,
// popped and compared by a monitor on every cpu_ready.
module tb_param_cache_ctrl;

  localparam logic [1:0] LD = 2'd0, ST = 2'd1, INV = 2'd2;

  logic         clk, rst, cpu_req, cpu_we, cpu_inv, mem_ack;
  logic [31:0]  cpu_addr, cpu_din, cpu_dout, mem_addr;
  logic         cpu_ready, cpu_hit, mem_req, mem_we;
  logic [127:0] mem_dout, mem_din;

  param_cache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_inv(cpu_inv),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ready(cpu_ready), .cpu_dout(cpu_dout),
    .cpu_hit(cpu_hit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dout;
    logic        hit;
    bit          chk_dout;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, expv);
    end
  endtask

  function automatic logic [127:0] mk(input logic [31:0] b);
    return {b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  always @(negedge clk) begin
    if (!rst && cpu_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready dout=%0h hit=%0b", cpu_dout, cpu_hit);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hit"}, cpu_hit, e.hit);
        if (e.chk_dout) chk({e.name, "_dout"}, cpu_dout, e.dout);
      end
    end
  end

  // called at a negedge; returns one negedge later with the request accepted
  task automatic issue(input string nm, input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] din, input logic [31:0] exp_dout,
                       input logic exp_hit, input bit cd);
    cpu_req = 1'b1; cpu_we = (op == ST); cpu_inv = (op == INV);
    cpu_addr = addr; cpu_din = din;
    sb.push_back('{dout: exp_dout, hit: exp_hit, chk_dout: cd, name: nm});
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_inv = 1'b0;
  endtask

  task automatic mem_service(input string nm, input logic exp_we, input logic [31:0] exp_addr,
                             input logic [127:0] exp_line, input bit chk_line,
                             input logic [127:0] fill, input int delay, input bit toggle);
    int n = 0;
    bit stable = 1'b1;
    logic [31:0]  a0;
    logic [127:0] d0;
    while (!mem_req && n < 40) begin @(negedge clk); n++; end
    chk({nm, "_memreq"}, mem_req, 1'b1);
    if (!mem_req) return;
    chk({nm, "_memwe"}, mem_we, exp_we);
    chk({nm, "_memaddr"}, mem_addr, exp_addr);
    if (chk_line) chk({nm, "_memdout"}, mem_dout, exp_line);
    a0 = mem_addr; d0 = mem_dout;
    for (int i = 0; i < delay; i++) begin
      if (toggle) begin cpu_req = ~cpu_req; cpu_addr = 32'h0000_0FF0; end
      @(negedge clk);
      if (!mem_req || mem_we !== exp_we || mem_addr !== a0 || mem_dout !== d0) stable = 1'b0;
    end
    if (delay > 0) chk({nm, "_stable"}, stable, 1'b1);
    cpu_req = 1'b0;
    mem_din = fill; mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  // exp_lat counts negedges after the call; -1 skips the latency check
  task automatic wait_done(input string nm, input int exp_lat, input bit nomem);
    int n = 0;
    bit sawmem = 1'b0;
    while (!cpu_ready && n < 60) begin
      @(negedge clk); n++;
      if (mem_req) sawmem = 1'b1;
    end
    chk({nm, "_ready"}, cpu_ready, 1'b1);
    if (exp_lat >= 0) chk({nm, "_lat"}, n, exp_lat);
    if (nomem) chk({nm, "_nomem"}, sawmem, 1'b0);
  endtask

  initial begin
    int n;
    int extra;
    clk = 0; rst = 1; cpu_req = 0; cpu_we = 0; cpu_inv = 0;
    cpu_addr = 0; cpu_din = 0; mem_din = 0; mem_ack = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", cpu_ready, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_dout", cpu_dout, 0);
    chk("rst_hit", cpu_hit, 0);
    chk("rst_memaddr", mem_addr, 0);
    chk("rst_memdout", mem_dout, 0);
    rst = 0;
    @(negedge clk);

    // 1: cold miss, fill, ready one cycle after ack
    issue("t1", LD, 32'h0000_0004, 0, 32'hAAAA_0001, 1'b0, 1'b1);
    mem_service("t1", 1'b0, 32'h0000_0000, 0, 1'b0, mk(32'hAAAA_0000), 0, 1'b0);
    wait_done("t1", 1, 1'b0);

    // 2: store hit and reload; issue spends the accepting cycle, so 1 more negedge
    issue("t2_st", ST, 32'h0000_0008, 32'h1111_1111, 0, 1'b1, 1'b0);
    wait_done("t2_st", 1, 1'b1);
    issue("t2_ld", LD, 32'h0000_0008, 0, 32'h1111_1111, 1'b1, 1'b1);
    wait_done("t2_ld", 1, 1'b1);

    // 3: fill way1, then evict dirty way0
    issue("t3_a", LD, 32'h0000_0400, 0, 32'hBBBB_0000, 1'b0, 1'b1);
    mem_service("t3_a", 1'b0, 32'h0000_0400, 0, 1'b0, mk(32'hBBBB_0000), 0, 1'b0);
    wait_done("t3_a", 1, 1'b0);
    issue("t3_b", LD, 32'h0000_0808, 0, 32'hCCCC_0002, 1'b0, 1'b1);
    mem_service("t3_wb", 1'b1, 32'h0000_0000,
                {32'hAAAA_0003, 32'h1111_1111, 32'hAAAA_0001, 32'hAAAA_0000}, 1'b1, 0, 0, 1'b0);
    mem_service("t3_al", 1'b0, 32'h0000_0800, 0, 1'b0, mk(32'hCCCC_0000), 0, 1'b0);
    wait_done("t3_b", 1, 1'b0);

    // 4: clean invalidate, then refill
    issue("t4_inv", INV, 32'h0000_0400, 0, 0, 1'b1, 1'b0);
    wait_done("t4_inv", 1, 1'b1);
    issue("t4_ld", LD, 32'h0000_0404, 0, 32'hBBBB_0001, 1'b0, 1'b1);
    mem_service("t4_ld", 1'b0, 32'h0000_0400, 0, 1'b0, mk(32'hBBBB_0000), 0, 1'b0);
    wait_done("t4_ld", 1, 1'b0);

    // 5: reset while a write-back is pending
    issue("t5_st", ST, 32'h0000_0800, 32'h2222_2222, 0, 1'b1, 1'b0);
    wait_done("t5_st", 1, 1'b1);
    issue("t5_ld", LD, 32'h0000_0400, 0, 32'hBBBB_0000, 1'b1, 1'b1);
    wait_done("t5_ld", 1, 1'b1);
    issue("t5_c00", LD, 32'h0000_0C00, 0, 0, 1'b0, 1'b0);
    n = 0;
    while (!mem_req && n < 40) begin @(negedge clk); n++; end
    chk("t5_wb_we", mem_we, 1'b1);
    chk("t5_wb_addr", mem_addr, 32'h0000_0800);
    rst = 1;
    @(negedge clk);
    chk("t5_rst_memreq", mem_req, 1'b0);
    chk("t5_rst_ready", cpu_ready, 1'b0);
    rst = 0;
    sb.delete();
    issue("t5_after", LD, 32'h0000_0800, 0, 32'hDDDD_0000, 1'b0, 1'b1);
    mem_service("t5_after", 1'b0, 32'h0000_0800, 0, 1'b0, mk(32'hDDDD_0000), 0, 1'b0);
    wait_done("t5_after", 1, 1'b0);

    // 6: delayed ack with cpu_req toggling, exactly one ready
    issue("t6_st", ST, 32'h0000_0800, 32'h3333_3333, 0, 1'b1, 1'b0);
    wait_done("t6_st", 1, 1'b1);
    issue("t6_a", LD, 32'h0000_0400, 0, 32'hEEEE_0000, 1'b0, 1'b1);
    mem_service("t6_a", 1'b0, 32'h0000_0400, 0, 1'b0, mk(32'hEEEE_0000), 0, 1'b0);
    wait_done("t6_a", 1, 1'b0);
    issue("t6_b", LD, 32'h0000_0C04, 0, 32'hFFFF_0001, 1'b0, 1'b1);
    mem_service("t6_wb", 1'b1, 32'h0000_0800,
                {32'hDDDD_0003, 32'hDDDD_0002, 32'hDDDD_0001, 32'h3333_3333}, 1'b1, 0, 5, 1'b1);
    mem_service("t6_al", 1'b0, 32'h0000_0C00, 0, 1'b0, mk(32'hFFFF_0000), 0, 1'b0);
    wait_done("t6_b", 1, 1'b0);
    extra = 0;
    repeat (4) begin @(negedge clk); if (cpu_ready) extra++; end
    chk("t6_single_ready", extra, 0);

    // 7: invalidate of a dirty hit writes back first, ready on ack
    issue("t7_st", ST, 32'h0000_0C00, 32'h4444_4444, 0, 1'b1, 1'b0);
    wait_done("t7_st", 1, 1'b1);
    issue("t7_inv", INV, 32'h0000_0C00, 0, 0, 1'b1, 1'b0);
    mem_service("t7_wb", 1'b1, 32'h0000_0C00,
                {32'hFFFF_0003, 32'hFFFF_0002, 32'hFFFF_0001, 32'h4444_4444}, 1'b1, 0, 0, 1'b0);
    wait_done("t7_inv", 0, 1'b0);
    issue("t7_ld", LD, 32'h0000_0C00, 0, 32'h1234_0000, 1'b0, 1'b1);
    mem_service("t7_ld", 1'b0, 32'h0000_0C00, 0, 1'b0, mk(32'h1234_0000), 0, 1'b0);
    wait_done("t7_ld", 1, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
